// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer: FSM states, opcode
// classes, condition codes and NZCV flag bit positions.
package seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_FETCH_WAIT,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_MEM_WAIT,
    ST_WB,
    ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LDR,
    CLS_STR,
    CLS_BR,
    CLS_NOP,
    CLS_HALT
  } op_class_e;

  localparam logic [3:0] OP_ALU_LAST = 4'h9;
  localparam logic [3:0] OP_LDR      = 4'hA;
  localparam logic [3:0] OP_STR      = 4'hB;
  localparam logic [3:0] OP_B        = 4'hC;
  localparam logic [3:0] OP_HALT     = 4'hF;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Opcode 0xC only classifies as a branch when the branch datapath exists.
  function automatic op_class_e op_class(input logic [3:0] op, input logic branch_en);
    op_class_e cls;
    cls = CLS_NOP;
    if (op <= OP_ALU_LAST)             cls = CLS_ALU;
    else if (op == OP_LDR)             cls = CLS_LDR;
    else if (op == OP_STR)             cls = CLS_STR;
    else if (op == OP_B && branch_en)  cls = CLS_BR;
    else if (op == OP_HALT)            cls = CLS_HALT;
    return cls;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator: decides whether a 4-bit condition
// holds against an {N,Z,C,V} flags vector.
module cond_eval
  import seq_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);

  logic n, z, c, v;
  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    pass_o = 1'b0;
    case (cond_i)
      COND_EQ: pass_o = z;
      COND_NE: pass_o = !z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = !c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = !n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = !v;
      COND_HI: pass_o = c && !z;
      COND_LS: pass_o = !c || z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = !z && (n == v);
      COND_LE: pass_o = z || (n != v);
      COND_AL: pass_o = 1'b1;
      COND_NV: pass_o = 1'b0;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer owning pc, instr and NZCV flags.
// Define INSTR_SEQ_BRANCH_EN to execute opcode 0xC as a branch; otherwise it is a NOP.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [31:0]       fetch_data,
  input  logic [3:0]        alu_flags,
  output logic [PC_W-1:0]   pc,
  output logic              fetch_en,
  output logic [ADDR_W-1:0] fetch_address,
  output logic [31:0]       instr,
  output logic              mem_en,
  output logic              mem_rw,
  output logic              reg_we,
  output logic              wb_sel,
  output logic [3:0]        flags,
  output logic              busy,
  output logic              halted
);

`ifdef INSTR_SEQ_BRANCH_EN
  localparam logic BRANCH_EN = 1'b1;
`else
  localparam logic BRANCH_EN = 1'b0;
`endif

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [3:0]      flags_q, flags_d;

  op_class_e cls;
  logic      cond_pass;

  assign cls = op_class(instr_q[27:24], BRANCH_EN);

  cond_eval u_cond_eval (
    .cond_i  (instr_q[31:28]),
    .flags_i (flags_q),
    .pass_o  (cond_pass)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge next-state value together.
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    flags_d = flags_q;
    case (state_q)
      ST_IDLE:       if (run) state_d = ST_FETCH;
      ST_FETCH:      state_d = ST_FETCH_WAIT;
      ST_FETCH_WAIT: begin
        instr_d = fetch_data;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (!cond_pass || cls == CLS_NOP) begin
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_IDLE;
        end else if (cls == CLS_HALT) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        pc_d = pc_q + PC_W'(1);
        case (cls)
          CLS_ALU: begin
            if (instr_q[23]) flags_d = alu_flags;
            state_d = ST_WB;
          end
          CLS_LDR, CLS_STR: state_d = ST_MEM;
`ifdef INSTR_SEQ_BRANCH_EN
          // Branch target is the low PC_W bits of im_val (instr[18:3]).
          CLS_BR: begin
            pc_d    = instr_q[3 +: PC_W];
            state_d = ST_IDLE;
          end
`endif
          default: state_d = ST_IDLE;
        endcase
      end
      ST_MEM:      state_d = (cls == CLS_STR) ? ST_IDLE : ST_MEM_WAIT;
      ST_MEM_WAIT: state_d = ST_WB;
      ST_WB:       state_d = ST_IDLE;
      ST_HALT:     state_d = ST_HALT;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Moore strobes: decoded from the state register and the latched instruction only.
  assign fetch_en      = (state_q == ST_FETCH);
  assign mem_en        = (state_q == ST_MEM);
  assign mem_rw        = (state_q == ST_MEM) && (cls == CLS_STR);
  assign reg_we        = (state_q == ST_WB);
  assign wb_sel        = (state_q == ST_MEM_WAIT) || ((state_q == ST_WB) && (cls == CLS_LDR));
  assign busy          = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign halted        = (state_q == ST_HALT);
  assign fetch_address = ADDR_W'(pc_q);
  assign pc            = pc_q;
  assign instr         = instr_q;
  assign flags         = flags_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer with a clocked fetch RAM model.
module tb_instr_sequencer;

  localparam int PC_W   = 8;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              run;
  logic [31:0]       fetch_data = '0;
  logic [3:0]        alu_flags;
  logic [PC_W-1:0]   pc;
  logic              fetch_en;
  logic [ADDR_W-1:0] fetch_address;
  logic [31:0]       instr;
  logic              mem_en, mem_rw, reg_we, wb_sel, busy, halted;
  logic [3:0]        flags;

  instr_sequencer #(.PC_W(PC_W), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .fetch_data    (fetch_data),
    .alu_flags     (alu_flags),
    .pc            (pc),
    .fetch_en      (fetch_en),
    .fetch_address (fetch_address),
    .instr         (instr),
    .mem_en        (mem_en),
    .mem_rw        (mem_rw),
    .reg_we        (reg_we),
    .wb_sel        (wb_sel),
    .flags         (flags),
    .busy          (busy),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [0:255];
  always @(posedge clk) if (fetch_en) fetch_data <= ram[fetch_address[7:0]];

  int checks = 0;
  int errors = 0;

  int          len;
  logic [15:0] a1;
  logic        s_fe [0:16];
  logic        s_me [0:16];
  logic        s_rw [0:16];
  logic        s_we [0:16];
  logic        s_ws [0:16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [3:0] c, input logic [3:0] op, input logic s);
    return {c, op, s, 23'b0};
  endfunction

  function automatic logic [31:0] mk_b(input logic [3:0] c, input logic [15:0] imm);
    return {c, 4'hC, 5'b0, imm, 3'b0};
  endfunction

  function automatic logic any_me();
    logic r;
    r = 1'b0;
    for (int i = 1; i <= len; i++) r |= s_me[i];
    return r;
  endfunction

  // Issues one instruction from IDLE and records strobes per cycle (cycle 1 = FETCH).
  task automatic run_one();
    for (int i = 0; i <= 16; i++) begin
      s_fe[i] = 0; s_me[i] = 0; s_rw[i] = 0; s_we[i] = 0; s_ws[i] = 0;
    end
    run = 1'b1;
    tick();
    run = 1'b0;
    len = 0;
    a1  = fetch_address;
    while (busy && len < 16) begin
      len++;
      s_fe[len] = fetch_en; s_me[len] = mem_en; s_rw[len] = mem_rw;
      s_we[len] = reg_we;   s_ws[len] = wb_sel;
      tick();
    end
    check("settle", {31'b0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) ram[i] = mk(4'hE, 4'hD, 1'b0);
    ram[0] = mk(4'hE, 4'h1, 1'b1);
    ram[1] = mk(4'hE, 4'h2, 1'b1);
    ram[2] = mk(4'h0, 4'hB, 1'b0);
    ram[3] = mk(4'hE, 4'hA, 1'b0);
    ram[4] = mk(4'hE, 4'h3, 1'b1);
    ram[5] = mk(4'h0, 4'hB, 1'b0);
    ram[6] = mk(4'h1, 4'h4, 1'b1);
    ram[7] = mk(4'hE, 4'hF, 1'b0);
    run = 1'b1;
    alu_flags = 4'b0000;
    do_reset();
    run = 1'b0;
    check("rst_pc", {24'b0, pc}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_flags", {28'b0, flags}, 32'd0);
    check("rst_strobes", {25'b0, fetch_en, mem_en, mem_rw, reg_we, wb_sel, busy, halted}, 32'd0);

    alu_flags = 4'b0100;
    run_one();
    check("alu_len", len, 5);
    check("alu_fetch_c1", {31'b0, s_fe[1]}, 1);
    check("alu_addr_c1", {16'b0, a1}, 0);
    check("alu_we_c4", {31'b0, s_we[4]}, 0);
    check("alu_we_c5", {31'b0, s_we[5]}, 1);
    check("alu_ws_c5", {31'b0, s_ws[5]}, 0);
    check("alu_flags", {28'b0, flags}, 32'h4);
    check("alu_pc", {24'b0, pc}, 1);

    alu_flags = 4'b0000;
    run_one();
    check("alu2_flags", {28'b0, flags}, 0);

    run_one();
    check("str_eqfail_len", len, 3);
    check("str_eqfail_mem", {31'b0, any_me()}, 0);
    check("str_eqfail_pc", {24'b0, pc}, 3);

    alu_flags = 4'b1111;
    run_one();
    check("ldr_addr_c1", {16'b0, a1}, 3);
    check("ldr_len", len, 7);
    check("ldr_me_c5", {30'b0, s_me[5], s_rw[5]}, 32'b10);
    check("ldr_we_c7", {30'b0, s_we[7], s_ws[7]}, 32'b11);
    check("ldr_ws_c6", {31'b0, s_ws[6]}, 1);
    check("ldr_pc", {24'b0, pc}, 4);
    check("ldr_flags", {28'b0, flags}, 0);

    alu_flags = 4'b0100;
    run_one();
    check("alu3_flags", {28'b0, flags}, 32'h4);

    run_one();
    check("str_eq_len", len, 5);
    check("str_eq_c5", {30'b0, s_me[5], s_rw[5]}, 32'b11);
    check("str_eq_we", {31'b0, s_we[5]}, 0);
    check("str_eq_pc", {24'b0, pc}, 6);

    alu_flags = 4'b1000;
    run_one();
    check("ne_fail_len", len, 3);
    check("ne_fail_flags", {28'b0, flags}, 32'h4);
    check("ne_fail_pc", {24'b0, pc}, 7);

    run_one();
    check("halt_len", len, 3);
    check("halt_halted", {31'b0, halted}, 1);
    check("halt_pc", {24'b0, pc}, 7);
    run = 1'b1;
    tick(); tick(); tick();
    check("halt_stay", {30'b0, halted, busy}, 32'b10);
    check("halt_pc_stay", {24'b0, pc}, 7);
    check("halt_no_fetch", {31'b0, fetch_en}, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run = 1'b0;
    check("halt_rst", {30'b0, halted, busy}, 0);
    check("halt_rst_pc", {24'b0, pc}, 0);

    // Walk reserved NOPs up to pc 0xFF, then branch from the top of memory.
    for (int i = 0; i < 256; i++) ram[i] = mk(4'hE, 4'hD, 1'b0);
    ram[255] = mk_b(4'hE, 16'h0042);
    n = 0;
    while (pc !== 8'hFF && n < 300) begin
      run_one();
      n++;
    end
    check("walk_pc", {24'b0, pc}, 32'hFF);
    check("nop_len", len, 3);
    run_one();
`ifdef INSTR_SEQ_BRANCH_EN
    check("b_len", len, 4);
    check("b_pc", {24'b0, pc}, 32'h42);
`else
    check("b_len", len, 3);
    check("b_pc", {24'b0, pc}, 32'h00);
`endif
    check("b_flags", {28'b0, flags}, 0);

    // Reset in the middle of a store.
    do_reset();
    ram[0] = mk(4'hE, 4'h5, 1'b1);
    ram[1] = mk(4'hE, 4'hB, 1'b0);
    alu_flags = 4'b1010;
    run_one();
    check("pre_flags", {28'b0, flags}, 32'hA);
    run = 1'b1;
    tick();
    run = 1'b0;
    tick(); tick(); tick(); tick();
    check("str_mid_mem", {30'b0, mem_en, mem_rw}, 32'b11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_strobes", {29'b0, mem_en, mem_rw, busy}, 0);
    check("abort_pc", {24'b0, pc}, 0);
    check("abort_flags", {28'b0, flags}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
